sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Sequential sprite renderer sitting directly downstream of the combinational sprite texture ROM. On a start strobe it walks one sprite's bitmap in the ROM, byte by byte, and serialises each byte into single-pixel framebuffer writes at a given screen position. Clear bits are transparent and off-screen pixels are clipped. The game controller drives it once per sprite per frame, and the framebuffer/display stage consumes its write port.

## Interface
- `SCR_W`, default 128: screen width in pixels.
- `SCR_H`, default 64: screen height in pixels.
- `XW`, default 8: width of the x/y coordinate ports.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request; accepted only in IDLE.
- `sprite_id`  in  2: 0 = t-rex, 1 = obstacle, 2/3 = invalid.
- `spr_x`, `spr_y`  in  XW: top-left screen position, sampled on accepted start.
- `erase`  in  1: sampled on start; 1 writes 0 for each set bit (undraw).
- `rom_addr`  out  10: texture ROM address.
- `rom_data`  in  8: texture ROM data, combinational from `rom_addr`.
- `fb_we`  out  1: pixel write strobe.
- `fb_x`, `fb_y`  out  XW: pixel coordinates.
- `fb_pix`  out  1: pixel value (`~erase`).
- `busy`  out  1: high in any non-IDLE state.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Sprite table (constants):
  - t-rex: base 0, 25 rows, 3 stripes.
  - obstacle: base 75, 28 rows, 2 stripes.
- Each stripe is 8 px wide. In each byte, bit 7 is the leftmost pixel.
- Address = base + stripe*rows + row. Traversal is stripe-major: stripe 0 rows 0..R-1, then stripe 1, and so on.
- FSM:
  - IDLE: accepted start goes to FETCH (valid id) or DONE (invalid id). Position, id and erase are latched.
  - FETCH: drive `rom_addr`; register `rom_data` into an 8-bit shift register at the clock edge.
  - EMIT: 8 cycles, k = 0..7, consuming bit 7-k.
    - Pixel: px = spr_x + 8*stripe + k, py = spr_y + row, both computed XW+2 bits wide (no wrap).
    - Write only if the bit is 1, px < SCR_W and py < SCR_H.
    - After k = 7, advance row/stripe: go to FETCH, or to DONE after the last byte.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Outputs `fb_*` are registered. A pixel decided in EMIT cycle k is visible the following cycle. `fb_we` otherwise returns to 0.
- Edge cases:
  - `start` while busy: ignored, with no effect on latched inputs.
  - Reset mid-operation: immediate return to IDLE with all outputs at reset values. No further writes.
  - `start` in the DONE cycle: ignored.

## Timing
- Reset values: `rom_addr` = 0, `fb_we` = 0, `fb_x` = 0, `fb_y` = 0, `fb_pix` = 0, `busy` = 0, `done` = 0, FSM = IDLE.
- Per byte: 9 cycles (1 FETCH + 8 EMIT).
- If `start` is accepted at edge 0, `done` is high in cycle 9N+1 (N = bytes):
  - t-rex: cycle 676.
  - obstacle: cycle 505.
  - invalid id: cycle 1.
- The final pixel's `fb_we` (if any) coincides with `done`.
- `busy` rises the cycle after the accepted start and falls the cycle after `done`.
- `rom_addr` is stable for the whole FETCH cycle.

## Structure
- Shared package `sprite_pkg` holds:
  - sprite ID constants;
  - the base/rows/stripes table;
  - ROM address width (10) and data width (8);
  - FSM state enum.
- One natural sub-module: `sprite_addr_gen`. It contains the row/stripe counters and address computation, and provides a `last_byte` flag, load and step inputs.
- Pixel clipping and the shift register stay in the top level.

## Test plan
- **T-rex at (0,0), draw:**
  - first `fb_we` at (1,9), pix = 1;
  - total writes equal the popcount of ROM bytes 0..74;
  - `done` at cycle 676.
- **Obstacle at (124,0):**
  - every stripe-1 write is clipped;
  - row 8 yields exactly (125,8), (126,8), (127,8);
  - no `fb_x` ≥ 128 ever;
  - `done` at cycle 505.
- **T-rex at (0,50):** no write with `fb_y` ≥ 64. Rows 14..24 are suppressed.
- **Erase mode:** same write set as draw mode, but every `fb_pix` = 0.
- **Invalid id 3:** `done` at cycle 1, zero `fb_we`, `rom_addr` unchanged.
- **Robustness:**
  - re-`start` at cycle 100 is ignored; trace is identical to an uninterrupted run;
  - `rst_n` low at cycle 300: all outputs 0 asynchronously, no writes after release until the next start.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite blitter slice.
//   - ROM geometry (address/data widths)
//   - sprite IDs and the base/rows/stripes descriptor table
//   - blitter FSM state encoding
package sprite_pkg;

  localparam int ROM_AW   = 10;
  localparam int ROM_DW   = 8;
  localparam int ROW_W    = 5;   // wide enough for the tallest sprite (28 rows)
  localparam int STRIPE_W = 2;

  localparam logic [1:0] ID_TREX     = 2'd0;
  localparam logic [1:0] ID_OBSTACLE = 2'd1;

  typedef struct packed {
    logic [ROM_AW-1:0]   base;
    logic [ROW_W-1:0]    rows;
    logic [STRIPE_W-1:0] stripes;
  } sprite_desc_t;

  localparam sprite_desc_t TREX_DESC     = '{base: 10'd0,  rows: 5'd25, stripes: 2'd3};
  localparam sprite_desc_t OBSTACLE_DESC = '{base: 10'd75, rows: 5'd28, stripes: 2'd2};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } state_t;

  function automatic logic sprite_valid(input logic [1:0] id);
    return (id == ID_TREX) || (id == ID_OBSTACLE);
  endfunction

  // Invalid IDs never reach the traversal, so they simply alias to t-rex here.
  function automatic sprite_desc_t sprite_lookup(input logic [1:0] id);
    return (id == ID_OBSTACLE) ? OBSTACLE_DESC : TREX_DESC;
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: bundles the blitter's request handshake, texture ROM
// port and framebuffer write port.
//   slave  : the blitter (consumes requests and ROM data, drives ROM address,
//            pixel writes and status)
//   master : the surrounding system (controller, ROM, framebuffer)
interface sprite_blitter_if #(
  parameter int XW = 8
) ();
  import sprite_pkg::*;

  // request / status
  logic              start;
  logic [1:0]        sprite_id;
  logic [XW-1:0]     spr_x;
  logic [XW-1:0]     spr_y;
  logic              erase;
  logic              busy;
  logic              done;
  // texture ROM
  logic [ROM_AW-1:0] rom_addr;
  logic [ROM_DW-1:0] rom_data;
  // framebuffer write port
  logic              fb_we;
  logic [XW-1:0]     fb_x;
  logic [XW-1:0]     fb_y;
  logic              fb_pix;

  modport slave (
    input  start, sprite_id, spr_x, spr_y, erase, rom_data,
    output rom_addr, fb_we, fb_x, fb_y, fb_pix, busy, done
  );

  modport master (
    output start, sprite_id, spr_x, spr_y, erase, rom_data,
    input  rom_addr, fb_we, fb_x, fb_y, fb_pix, busy, done
  );

endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: row/stripe walker for one sprite bitmap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new traversal for sprite_id (row 0, stripe 0)
//   sprite_id  : sprite to walk, sampled on load
//   step       : advance to the next byte (stripe-major); held at the last byte
//   addr       : registered ROM address = base + stripe*rows + row
//   row, stripe: current position within the sprite
//   last_byte  : current byte is the final one of the sprite
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [1:0]          sprite_id,
  input  logic                step,
  output logic [ROM_AW-1:0]   addr,
  output logic [ROW_W-1:0]    row,
  output logic [STRIPE_W-1:0] stripe,
  output logic                last_byte
);

  logic [1:0]          id_reg;
  logic [ROW_W-1:0]    row_reg, row_next;
  logic [STRIPE_W-1:0] stripe_reg, stripe_next;
  logic [ROM_AW-1:0]   addr_reg, addr_next;
  sprite_desc_t        desc;
  sprite_desc_t        load_desc;
  logic                last_row;

  assign desc      = sprite_lookup(id_reg);
  assign load_desc = sprite_lookup(sprite_id);
  assign last_row  = (row_reg == desc.rows - ROW_W'(1));
  assign last_byte = last_row && (stripe_reg == desc.stripes - STRIPE_W'(1));

  always_comb begin
    row_next    = row_reg;
    stripe_next = stripe_reg;
    addr_next   = addr_reg;
    if (load) begin
      row_next    = '0;
      stripe_next = '0;
      addr_next   = load_desc.base;
    end else if (step && !last_byte) begin
      // Holding at the last byte keeps rom_addr on the final address after DONE.
      if (last_row) begin
        row_next    = '0;
        stripe_next = stripe_reg + STRIPE_W'(1);
      end else begin
        row_next = row_reg + ROW_W'(1);
      end
      addr_next = desc.base + ROM_AW'(stripe_next) * ROM_AW'(desc.rows) + ROM_AW'(row_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_reg     <= '0;
      row_reg    <= '0;
      stripe_reg <= '0;
      addr_reg   <= '0;
    end else begin
      if (load) begin
        id_reg <= sprite_id;
      end
      row_reg    <= row_next;
      stripe_reg <= stripe_next;
      addr_reg   <= addr_next;
    end
  end

  assign addr   = addr_reg;
  assign row    = row_reg;
  assign stripe = stripe_reg;

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one sprite bitmap in the texture ROM and serialises
// each byte (bit 7 = leftmost) into single-pixel framebuffer writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sprite_blitter_if.slave
//                start/sprite_id/spr_x/spr_y/erase in, busy/done out,
//                rom_addr out / rom_data in (combinational ROM),
//                fb_we/fb_x/fb_y/fb_pix out (registered)
// Clear bits are transparent; pixels at or beyond SCR_W/SCR_H are clipped.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SCR_W = 128,
  parameter int SCR_H = 64,
  parameter int XW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sprite_blitter_if.slave  bus
);

  // Pixel coordinates carry two extra bits so off-screen positions never wrap
  // back onto the screen.
  localparam int            PW    = XW + 2;
  localparam logic [PW-1:0] X_LIM = PW'(SCR_W);
  localparam logic [PW-1:0] Y_LIM = PW'(SCR_H);

  state_t              state_reg, state_next;
  logic [XW-1:0]       x_reg, y_reg;
  logic                erase_reg;
  logic [ROM_DW-1:0]   shift_reg;
  logic [2:0]          bit_idx_reg;
  logic                accept, addr_load, addr_step, last_byte;
  logic [ROW_W-1:0]    row;
  logic [STRIPE_W-1:0] stripe;
  logic [ROM_AW-1:0]   addr;
  logic [PW-1:0]       px, py;
  logic                hit;
  logic                fb_we_reg, fb_pix_reg;
  logic [XW-1:0]       fb_x_reg, fb_y_reg;

  sprite_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (addr_load),
    .sprite_id (bus.sprite_id),
    .step      (addr_step),
    .addr      (addr),
    .row       (row),
    .stripe    (stripe),
    .last_byte (last_byte)
  );

  assign accept = (state_reg == ST_IDLE) && bus.start;

  always_comb begin
    state_next = state_reg;
    addr_load  = 1'b0;
    addr_step  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          if (sprite_valid(bus.sprite_id)) begin
            state_next = ST_FETCH;
            addr_load  = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_FETCH: state_next = ST_EMIT;
      ST_EMIT: begin
        if (bit_idx_reg == 3'd7) begin
          addr_step  = 1'b1;
          state_next = last_byte ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Current byte's MSB is the pixel under consideration this EMIT cycle.
  assign px  = PW'(x_reg) + PW'({stripe, 3'b000}) + PW'(bit_idx_reg);
  assign py  = PW'(y_reg) + PW'(row);
  assign hit = (state_reg == ST_EMIT) && shift_reg[ROM_DW-1] && (px < X_LIM) && (py < Y_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      erase_reg   <= 1'b0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      fb_we_reg   <= 1'b0;
      fb_x_reg    <= '0;
      fb_y_reg    <= '0;
      fb_pix_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg     <= bus.spr_x;
        y_reg     <= bus.spr_y;
        erase_reg <= bus.erase;
      end
      if (state_reg == ST_FETCH) begin
        shift_reg   <= bus.rom_data;
        bit_idx_reg <= '0;
      end else if (state_reg == ST_EMIT) begin
        shift_reg   <= {shift_reg[ROM_DW-2:0], 1'b0};
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
      fb_we_reg <= hit;
      if (hit) begin
        fb_x_reg   <= px[XW-1:0];
        fb_y_reg   <= py[XW-1:0];
        fb_pix_reg <= ~erase_reg;
      end
    end
  end

  assign bus.rom_addr = addr;
  assign bus.fb_we    = fb_we_reg;
  assign bus.fb_x     = fb_x_reg;
  assign bus.fb_y     = fb_y_reg;
  assign bus.fb_pix   = fb_pix_reg;
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural texture ROM and a
// reference model of the expected pixel-write trace.
module tb_sprite_blitter;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        pix;
    logic [31:0] cyc;
  } wr_t;

  logic clk;
  logic rst_n;
  logic [7:0] rom [0:1023];

  int checks   = 0;
  int failures = 0;
  int cyc;
  int done_cyc;
  logic [9:0] addr_c1;
  wr_t got_q[$];
  wr_t exp_q[$];

  sprite_blitter_if #(.XW(8)) bus ();

  sprite_blitter #(.SCR_W(128), .SCR_H(64), .XW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected write trace: stripe-major walk, bit 7 first, clipped to 128x64.
  // EMIT cycle k of byte b is cycle 9b+2+k; its write is visible one cycle later.
  task automatic build_exp(input logic [1:0] id, input int x, input int y, input logic er);
    int base, rows, stripes, b, px, py;
    logic [7:0] d;
    exp_q.delete();
    base = 0; rows = 0; stripes = 0;
    if (id == 2'd0) begin base = 0;  rows = 25; stripes = 3; end
    if (id == 2'd1) begin base = 75; rows = 28; stripes = 2; end
    for (int s = 0; s < stripes; s++) begin
      for (int r = 0; r < rows; r++) begin
        b = s * rows + r;
        d = rom[base + b];
        for (int k = 0; k < 8; k++) begin
          if (d[7-k]) begin
            px = x + 8 * s + k;
            py = y + r;
            if (px < 128 && py < 64)
              exp_q.push_back(wr_t'{x: 8'(px), y: 8'(py), pix: ~er, cyc: 32'(9 * b + 3 + k)});
          end
        end
      end
    end
  endtask

  task automatic compare_trace(input string tag);
    int nbad, n;
    nbad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    check({tag, "_content"}, 32'(nbad), 32'd0);
    $display("txn %s: writes=%0d expected=%0d done_cyc=%0d", tag, got_q.size(), exp_q.size(), done_cyc);
  endtask

  // Issue one start, collect writes until done (bounded). Optionally pulse a
  // second start with different arguments at cycle restart_at.
  task automatic run_sprite(input logic [1:0] id, input logic [7:0] x, input logic [7:0] y,
                            input logic er, input int restart_at, input string tag);
    got_q.delete();
    done_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.sprite_id = id; bus.spr_x = x; bus.spr_y = y; bus.erase = er;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    addr_c1 = bus.rom_addr;
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    while (done_cyc == 0 && cyc < 2000) begin
      if (bus.fb_we) got_q.push_back(wr_t'{x: bus.fb_x, y: bus.fb_y, pix: bus.fb_pix, cyc: 32'(cyc)});
      if (bus.done) done_cyc = cyc;
      if (cyc == restart_at) begin
        bus.start = 1'b1; bus.sprite_id = 2'd1; bus.spr_x = 8'd200; bus.spr_y = 8'd7; bus.erase = ~er;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_busy_fall"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    int pc, bad, r8n;
    logic [23:0] r8x;
    wr_t first;

    for (int a = 0; a < 1024; a++) rom[a] = 8'((a * 73 + 29) ^ (a >> 2));
    for (int a = 0; a < 9; a++) rom[a] = 8'h00;
    rom[9]  = 8'h5C;   // first set pixel of t-rex: row 9, column 1
    rom[83] = 8'h7A;   // obstacle stripe 0 row 8: columns 1..3 set, plus 4 and 6

    rst_n = 1'b0;
    bus.start = 1'b0; bus.sprite_id = 2'd0; bus.spr_x = 8'd0; bus.spr_y = 8'd0; bus.erase = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("reset_fb", {bus.fb_we, bus.fb_pix, bus.fb_x, bus.fb_y}, 32'd0);
    check("reset_status", {bus.busy, bus.done}, 32'd0);
    $display("txn reset: busy=%0d done=%0d fb_we=%0d", bus.busy, bus.done, bus.fb_we);
    rst_n = 1'b1;
    @(negedge clk);

    // T-rex at (0,0), draw
    run_sprite(2'd0, 8'd0, 8'd0, 1'b0, 0, "trex_00");
    check("trex_00_done_cyc", 32'(done_cyc), 32'd676);
    check("trex_00_addr_c1", 32'(addr_c1), 32'd0);
    first = (got_q.size() > 0) ? got_q[0] : '0;
    check("trex_00_first_xy", {first.x, first.y, 7'd0, first.pix}, {8'd1, 8'd9, 8'd1});
    check("trex_00_first_cyc", first.cyc, 32'd85);
    pc = 0;
    for (int a = 0; a < 75; a++) pc += $countones(rom[a]);
    check("trex_00_popcount", 32'(got_q.size()), 32'(pc));
    build_exp(2'd0, 0, 0, 1'b0);
    compare_trace("trex_00");

    // Obstacle at (124,0): stripe 1 fully clipped
    run_sprite(2'd1, 8'd124, 8'd0, 1'b0, 0, "obst_124");
    check("obst_done_cyc", 32'(done_cyc), 32'd505);
    check("obst_addr_c1", 32'(addr_c1), 32'd75);
    bad = 0; r8n = 0; r8x = '0;
    foreach (got_q[i]) begin
      if (got_q[i].x >= 8'd128) bad++;
      if (got_q[i].y == 8'd8) begin
        r8x = {r8x[15:0], got_q[i].x};
        r8n++;
      end
    end
    check("obst_x_clip", 32'(bad), 32'd0);
    check("obst_row8_n", 32'(r8n), 32'd3);
    check("obst_row8_x", {8'd0, r8x}, {8'd0, 8'd125, 8'd126, 8'd127});
    build_exp(2'd1, 124, 0, 1'b0);
    compare_trace("obst_124");

    // T-rex at (0,50): rows 14..24 fall off the bottom
    run_sprite(2'd0, 8'd0, 8'd50, 1'b0, 0, "trex_y50");
    check("trex_y50_done_cyc", 32'(done_cyc), 32'd676);
    bad = 0;
    foreach (got_q[i]) if (got_q[i].y >= 8'd64 || got_q[i].y < 8'd50) bad++;
    check("trex_y50_y_clip", 32'(bad), 32'd0);
    build_exp(2'd0, 0, 50, 1'b0);
    compare_trace("trex_y50");

    // Erase mode: same positions, pixel value 0
    run_sprite(2'd0, 8'd10, 8'd5, 1'b1, 0, "trex_erase");
    bad = 0;
    foreach (got_q[i]) if (got_q[i].pix !== 1'b0) bad++;
    check("erase_pix_zero", 32'(bad), 32'd0);
    build_exp(2'd0, 10, 5, 1'b1);
    compare_trace("trex_erase");

    // Invalid id 3: immediate done, no writes, ROM address left at t-rex's last byte
    run_sprite(2'd3, 8'd20, 8'd20, 1'b0, 0, "invalid");
    check("invalid_done_cyc", 32'(done_cyc), 32'd1);
    check("invalid_writes", 32'(got_q.size()), 32'd0);
    check("invalid_rom_addr", 32'(bus.rom_addr), 32'd74);

    // Re-start while busy is ignored
    run_sprite(2'd0, 8'd3, 8'd2, 1'b0, 100, "trex_restart");
    check("restart_done_cyc", 32'(done_cyc), 32'd676);
    build_exp(2'd0, 3, 2, 1'b0);
    compare_trace("trex_restart");

    // Asynchronous reset mid-sprite
    @(negedge clk);
    bus.start = 1'b1; bus.sprite_id = 2'd0; bus.spr_x = 8'd0; bus.spr_y = 8'd0; bus.erase = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (299) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_fb", {bus.fb_we, bus.fb_pix, bus.fb_x, bus.fb_y}, 32'd0);
    check("async_rst_status", {20'd0, bus.busy, bus.done, bus.rom_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (bus.fb_we || bus.busy || bus.done) bad++;
    end
    check("post_reset_quiet", 32'(bad), 32'd0);
    $display("txn reset_mid: activity_after_release=%0d", bad);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
